alu_sequencer: RTL and testbench

//  Command-driven controller that sequences the 8-bit alu (processing unit + flag register + shifter).

---
 rtl/alu_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_sequencer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for the 8-bit alu: owns a small register file and runs one command at a time.
// Optional ALU_SEQ_COND_EN adds flag-conditioned EXEC (skip when the condition is false).
module alu_sequencer #(
  parameter  int MAX_WIDTH = 8,
  parameter  int NREGS     = 4,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [2:0]           cmd_selop,
  input  logic [1:0]           cmd_shamt,
  input  logic                 cmd_setf,
  input  logic [1:0]           cmd_cond,
  input  logic [AW-1:0]        cmd_ra,
  input  logic [AW-1:0]        cmd_rb,
  input  logic [AW-1:0]        cmd_rd,
  input  logic [MAX_WIDTH-1:0] cmd_imm,
  output logic [MAX_WIDTH-1:0] alu_busA,
  output logic [MAX_WIDTH-1:0] alu_busB,
  output logic [2:0]           alu_selop,
  output logic [1:0]           alu_shamt,
  output logic                 alu_enaf,
  input  logic [MAX_WIDTH-1:0] alu_busC,
  input  logic                 alu_C,
  input  logic                 alu_N,
  input  logic                 alu_P,
  input  logic                 alu_Z,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [MAX_WIDTH-1:0] rsp_data,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_skip
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SAMPLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam logic [1:0] OP_EXEC  = 2'd0;
  localparam logic [1:0] OP_LOADI = 2'd1;
  localparam logic [1:0] OP_READ  = 2'd2;

  state_t state, state_nxt;

  logic [MAX_WIDTH-1:0] rf [NREGS];
  logic [AW-1:0]        rd_q;
  logic                 wr_q;
  logic                 setf_q;
  logic                 cond_ok;
  logic                 accept;
  logic [3:0]           flags;

  assign flags  = {alu_C, alu_N, alu_P, alu_Z};
  assign accept = cmd_valid & cmd_ready;

`ifdef ALU_SEQ_COND_EN
  always_comb begin
    cond_ok = 1'b1;
    unique case (cmd_cond)
      2'd0:    cond_ok = 1'b1;
      2'd1:    cond_ok = alu_Z;
      2'd2:    cond_ok = alu_C;
      default: cond_ok = alu_N;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^cmd_cond;
  assign cond_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // enaf is gated by state so an async reset drops it immediately
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_enaf  = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          state_nxt = (cmd_op == OP_EXEC) ? EXEC : RESP;
      end
      EXEC: begin
        alu_enaf  = setf_q;
        state_nxt = SAMPLE;
      end
      SAMPLE: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      alu_busA  <= '0;
      alu_busB  <= '0;
      alu_selop <= '0;
      alu_shamt <= '0;
      rd_q      <= '0;
      wr_q      <= 1'b0;
      setf_q    <= 1'b0;
      rsp_data  <= '0;
      rsp_flags <= '0;
      rsp_skip  <= 1'b0;
    end else begin
      if (accept) begin
        rsp_skip  <= 1'b0;
        rsp_flags <= flags;
        unique case (cmd_op)
          OP_EXEC: begin
            alu_busA  <= rf[cmd_ra];
            alu_busB  <= rf[cmd_rb];
            alu_selop <= cmd_selop;
            alu_shamt <= cmd_shamt;
            rd_q      <= cmd_rd;
            wr_q      <= cond_ok;
            setf_q    <= cmd_setf & cond_ok;
            rsp_skip  <= ~cond_ok;
            // a skipped EXEC reports the untouched destination
            rsp_data  <= rf[cmd_rd];
          end
          OP_LOADI: begin
            rf[cmd_rd] <= cmd_imm;
            rsp_data   <= cmd_imm;
          end
          OP_READ: rsp_data <= rf[cmd_ra];
          default: rsp_data <= '0;
        endcase
      end
      if (state == EXEC && wr_q) begin
        rf[rd_q] <= alu_busC;
        rsp_data <= alu_busC;
      end
      if (state == SAMPLE) rsp_flags <= flags;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: vector table + scoreboard queue, alu stub, multi-cycle corner sequences.
// Define ALU_SEQ_COND_EN for both files to exercise conditional EXEC.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = '0;
  logic [2:0] cmd_selop = '0;
  logic [1:0] cmd_shamt = '0;
  logic       cmd_setf = 1'b0;
  logic [1:0] cmd_cond = '0;
  logic [1:0] cmd_ra = '0;
  logic [1:0] cmd_rb = '0;
  logic [1:0] cmd_rd = '0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] alu_busA, alu_busB, alu_busC;
  logic [2:0] alu_selop;
  logic [1:0] alu_shamt;
  logic       alu_enaf;
  logic       alu_C, alu_N, alu_P, alu_Z;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic [3:0] rsp_flags;
  logic       rsp_skip;

  always #5 clk = ~clk;

  alu_sequencer #(.MAX_WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_selop(cmd_selop),
    .cmd_shamt(cmd_shamt), .cmd_setf(cmd_setf),
    .cmd_cond(cmd_cond), .cmd_ra(cmd_ra),
    .cmd_rb(cmd_rb), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm),
    .alu_busA(alu_busA), .alu_busB(alu_busB),
    .alu_selop(alu_selop), .alu_shamt(alu_shamt),
    .alu_enaf(alu_enaf), .alu_busC(alu_busC),
    .alu_C(alu_C), .alu_N(alu_N),
    .alu_P(alu_P), .alu_Z(alu_Z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_skip(rsp_skip)
  );

  // alu stub: add on selop 0, pass busA otherwise
  logic [8:0] sum;
  always_comb begin
    sum = (alu_selop == 3'd0) ? ({1'b0, alu_busA} + {1'b0, alu_busB})
                              : {1'b0, alu_busA};
  end
  assign alu_busC = sum[7:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {alu_C, alu_N, alu_P, alu_Z} <= '0;
    else if (alu_enaf)
      {alu_C, alu_N, alu_P, alu_Z} <= {sum[8], sum[7], ^sum[7:0], sum[7:0] == 8'h00};
  end

  typedef struct {
    logic [1:0] op;
    logic [2:0] selop;
    logic       setf;
    logic [1:0] cond;
    logic [1:0] ra, rb, rd;
    logic [7:0] imm;
    logic [7:0] data;
    logic [3:0] flags;
    logic       skip;
    int         trace;
    logic [7:0] ta, tb;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [3:0] flags;
    logic       skip;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   acc = 0;
  int   hs = 0;

  always @(posedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) acc <= acc + 1;
      if (rsp_valid && rsp_ready) hs <= hs + 1;
    end
  end

  function automatic vec_t mk(input logic [1:0] op, input logic [2:0] sel,
                              input logic setf, input logic [1:0] cond,
                              input logic [1:0] ra, input logic [1:0] rb,
                              input logic [1:0] rd, input logic [7:0] imm,
                              input logic [7:0] data, input logic [3:0] flags,
                              input logic skip);
    vec_t v;
    v.op = op; v.selop = sel; v.setf = setf; v.cond = cond;
    v.ra = ra; v.rb = rb; v.rd = rd; v.imm = imm;
    v.data = data; v.flags = flags; v.skip = skip;
    v.trace = 0; v.ta = '0; v.tb = '0;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input vec_t v);
    int k;
    exp_t e;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op = v.op; cmd_selop = v.selop; cmd_setf = v.setf;
    cmd_cond = v.cond; cmd_ra = v.ra; cmd_rb = v.rb;
    cmd_rd = v.rd; cmd_imm = v.imm; cmd_shamt = '0;
    cmd_valid = 1'b1;
    e.data = v.data; e.flags = v.flags; e.skip = v.skip;
    sb.push_back(e);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int k;
    exp_t e;
    k = 0;
    while (!rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!rsp_valid) begin
      chk("rsp_valid_timeout", 32'(rsp_valid), 32'd1);
    end else if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("rsp_data", 32'(rsp_data), 32'(e.data));
      chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
      chk("rsp_skip", 32'(rsp_skip), 32'(e.skip));
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    send(v);
    if (v.trace == 1) begin
      chk("exec_busA", 32'(alu_busA), 32'(v.ta));
      chk("exec_busB", 32'(alu_busB), 32'(v.tb));
      chk("exec_enaf", 32'(alu_enaf), 32'd1);
      chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("sample_enaf", 32'(alu_enaf), 32'd0);
      chk("sample_rsp_valid", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
      chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    end else if (v.trace == 2) begin
      chk("skip_enaf", 32'(alu_enaf), 32'd0);
    end
    wait_rsp();
  endtask

  initial begin
    vec_t v;
    int a0, h0;

    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 8'h05, 8'h05, 4'b0000, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h03, 8'h03, 4'b0000, 1'b0));
    tbl.push_back(mk(2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 8'h00, 8'h08, 4'b0010, 1'b0));
    tbl[2].trace = 1; tbl[2].ta = 8'h05; tbl[2].tb = 8'h03;
    tbl.push_back(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h08, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 8'hFF, 8'hFF, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h01, 8'h01, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 8'h00, 8'h00, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h03, 8'h03, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd0, 1'b0, 2'd0, 2'd1, 2'd2, 2'd3, 8'h00, 8'h02, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h02, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 8'h02, 8'h02, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h02, 8'h02, 4'b1001, 1'b0));
    tbl.push_back(mk(2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd1, 8'h00, 8'h04, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 8'h00, 8'h04, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd3, 3'd0, 1'b0, 2'd0, 2'd2, 2'd0, 2'd1, 8'hAA, 8'h00, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd0, 3'd5, 1'b1, 2'd0, 2'd3, 2'd1, 2'd0, 8'h00, 8'h02, 4'b0010, 1'b0));
    tbl.push_back(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 8'h00, 8'h02, 4'b0010, 1'b0));

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_enaf", 32'(alu_enaf), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busA", 32'(alu_busA), 32'd0);
    rst = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // backpressure: response held stable, no new command accepted
    rsp_ready = 1'b0;
    send(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd1, 2'd0, 2'd0, 8'h00, 8'h04, 4'b0010, 1'b0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_data", 32'(rsp_data), 32'h04);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    wait_rsp();
    run_vec(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h02, 4'b0010, 1'b0));

    // cmd_valid held: one accept per handshake
    @(negedge clk);
    cmd_op = 2'd2; cmd_ra = 2'd2; cmd_valid = 1'b1;
    a0 = acc; h0 = hs;
    repeat (12) @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_accepts", 32'(acc - a0), 32'd6);
    chk("b2b_handshakes", 32'(hs - h0), 32'd6);

    // reset in the middle of EXEC
    send(mk(2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd3, 8'h00, 8'h04, 4'b0010, 1'b0));
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_enaf", 32'(alu_enaf), 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      v = mk(2'd2, 3'd0, 1'b0, 2'd0, 2'(r), 2'd0, 2'd0, 8'h00, 8'h00, 4'b0000, 1'b0);
      run_vec(v);
    end

`ifdef ALU_SEQ_COND_EN
    run_vec(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 8'h05, 8'h05, 4'b0000, 1'b0));
    run_vec(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h03, 8'h03, 4'b0000, 1'b0));
    run_vec(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd3, 8'h77, 8'h77, 4'b0000, 1'b0));
    v = mk(2'd0, 3'd0, 1'b1, 2'd1, 2'd1, 2'd2, 2'd3, 8'h00, 8'h77, 4'b0000, 1'b1);
    v.trace = 2;
    run_vec(v);
    run_vec(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h77, 4'b0000, 1'b0));
    run_vec(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 8'hFF, 8'hFF, 4'b0000, 1'b0));
    run_vec(mk(2'd1, 3'd0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd2, 8'h01, 8'h01, 4'b0000, 1'b0));
    run_vec(mk(2'd0, 3'd0, 1'b1, 2'd0, 2'd1, 2'd2, 2'd0, 8'h00, 8'h00, 4'b1001, 1'b0));
    run_vec(mk(2'd0, 3'd0, 1'b1, 2'd1, 2'd1, 2'd2, 2'd3, 8'h00, 8'h00, 4'b1001, 1'b0));
    run_vec(mk(2'd2, 3'd0, 1'b0, 2'd0, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 4'b1001, 1'b0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
